// File: rtl/cb_byte_stuffer.sv
// JPEG byte stuffer for the Cb entropy stream: expands 0xFF into 0xFF 0x00,
// repacks the byte stream into 32-bit words and flushes a tagged last word.
module cb_byte_stuffer #(
    parameter int BUF_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    input  logic        final_in,
    input  logic [4:0]  final_bits,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic [2:0]  out_bytes,
    output logic        busy,
    output logic        overflow
);

    localparam int OCC_W  = $clog2(BUF_BYTES + 1);
    localparam int WORK_N = BUF_BYTES + 8;

    typedef enum logic {RUN, DRAIN} state_t;

    typedef struct packed {
        logic [63:0] bytes;
        logic [3:0]  cnt;
    } exp_t;

    // Split a word MSB-first, pad a final word's partial byte with 1s, stuff 0x00 after 0xFF.
    function automatic exp_t expand(input logic [31:0] word, input logic fin, input logic [4:0] fbits);
        exp_t        r;
        logic [31:0] w;
        logic [7:0]  b;
        int          n;
        int          pos;
        r   = '0;
        w   = word;
        n   = 4;
        pos = 0;
        if (fin) begin
            n = (int'(fbits) + 7) / 8;
            w = word | (32'hFFFF_FFFF >> fbits);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                b = w[31-8*i -: 8];
                r.bytes[63-8*pos -: 8] = b;
                pos++;
                if (b == 8'hFF) begin
                    r.bytes[63-8*pos -: 8] = 8'h00;
                    pos++;
                end
            end
        end
        r.cnt = 4'(pos);
        return r;
    endfunction

    state_t           state;
    state_t           state_next;
    logic             accept;
    exp_t             ex;
    logic [63:0]      bytes_p1;
    logic [3:0]       cnt_p1;
    logic             vld_p1;
    logic [7:0]       buf_q    [BUF_BYTES];
    logic [7:0]       buf_next [BUF_BYTES];
    logic [7:0]       work     [WORK_N];
    logic [OCC_W-1:0] occ;
    int               occ_i;
    int               cnt_i;
    int               total;
    int               occ_next;
    logic             ovf_hit;
    logic             last_now;
    logic             pop4;

    assign accept = (state == RUN) && (data_valid || final_in);
    assign ex     = expand(data_in, final_in, final_bits);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (accept && final_in) state_next = DRAIN;
            DRAIN:   if (last_now)           state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        busy = (state == DRAIN);
    end

    // Stage 1: expanded bytes of the accepted word
    always_ff @(posedge clk) begin
        bytes_p1 <= ex.bytes;
        if (rst) begin
            vld_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            cnt_p1 <= accept ? ex.cnt : 4'd0;
        end
    end

    // Stage 2: buffered bytes and the incoming stage-1 bytes form one queue;
    // popping from the combined view gives the two-cycle input-to-output latency.
    always_comb begin
        occ_i = int'(occ);
        cnt_i = int'(cnt_p1);
        for (int i = 0; i < BUF_BYTES; i++) work[i] = (i < occ_i) ? buf_q[i] : 8'h00;
        for (int i = BUF_BYTES; i < WORK_N; i++) work[i] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (k < cnt_i) work[occ_i + k] = bytes_p1[63-8*k -: 8];
        end
        total   = occ_i + cnt_i;
        ovf_hit = (total > BUF_BYTES);
        if (ovf_hit) total = BUF_BYTES;
        last_now = (state == DRAIN) && !vld_p1 && (occ_i <= 4);
        pop4     = !last_now && (total >= 4);
        if (last_now)  occ_next = 0;
        else if (pop4) occ_next = total - 4;
        else           occ_next = total;
        for (int i = 0; i < BUF_BYTES; i++) buf_next[i] = pop4 ? work[i+4] : work[i];
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_next;
        if (rst) begin
            occ       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_bytes <= '0;
            overflow  <= 1'b0;
        end else begin
            occ       <= OCC_W'(occ_next);
            out_valid <= last_now || pop4;
            out_last  <= last_now;
            if (last_now || pop4) begin
                out_data  <= {work[0], work[1], work[2], work[3]};
                out_bytes <= last_now ? 3'(occ_i) : 3'd4;
            end
            if (ovf_hit) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cb_byte_stuffer.sv
// Bench for cb_byte_stuffer: fixed vector table plus randomized traffic
// compared each cycle against a byte-queue reference model.
module tb_cb_byte_stuffer;

    localparam int BUF = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_valid;
    logic        final_in;
    logic [4:0]  final_bits;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [2:0]  out_bytes;
    logic        busy;
    logic        overflow;

    always #5 clk = ~clk;

    cb_byte_stuffer #(.BUF_BYTES(BUF)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .final_in(final_in), .final_bits(final_bits), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_bytes(out_bytes),
        .busy(busy), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the stuffed stream as a plain byte queue
    logic [7:0]  mq[$];
    logic [7:0]  pend[$];
    bit          pend_v, m_drain, m_ovf, m_valid, m_last;
    logic [31:0] m_data;
    logic [2:0]  m_bytes;

    task automatic model_edge(input bit r, input bit dv, input bit fin,
                              input logic [4:0] fb, input logic [31:0] w);
        logic [7:0] t[$];
        logic [7:0] b;
        bit acc, lastw;
        int nbits, nbytes, left;
        if (r) begin
            mq.delete(); pend.delete();
            pend_v = 0; m_drain = 0; m_ovf = 0; m_valid = 0; m_last = 0;
            m_data = '0; m_bytes = '0;
            return;
        end
        acc   = !m_drain && (dv || fin);
        lastw = m_drain && !pend_v && (mq.size() <= 4);
        t = mq;
        foreach (pend[i]) t.push_back(pend[i]);
        while (t.size() > BUF) begin
            void'(t.pop_back());
            m_ovf = 1;
        end
        m_valid = 0; m_last = 0;
        if (lastw) begin
            m_data = '0;
            for (int i = 0; i < t.size(); i++) m_data[31-8*i -: 8] = t[i];
            m_bytes = 3'(t.size());
            m_valid = 1; m_last = 1; m_drain = 0;
            t.delete();
        end else if (t.size() >= 4) begin
            m_data = {t[0], t[1], t[2], t[3]};
            repeat (4) void'(t.pop_front());
            m_valid = 1; m_bytes = 3'd4;
        end
        mq = t;
        pend.delete();
        pend_v = acc;
        if (acc) begin
            nbits  = fin ? int'(fb) : 32;
            nbytes = (nbits + 7) / 8;
            for (int i = 0; i < nbytes; i++) begin
                b    = w[31-8*i -: 8];
                left = nbits - 8*i;
                if (left < 8) b = b | (8'hFF >> left);
                pend.push_back(b);
                if (b == 8'hFF) pend.push_back(8'h00);
            end
            if (fin) m_drain = 1;
        end
    endtask

    task automatic compare(input string name, input bit ev, input bit el, input logic [31:0] ed,
                           input logic [2:0] eb, input bit ebusy, input bit eovf);
        checks++;
        if (out_valid !== ev || out_last !== el || out_data !== ed || out_bytes !== eb ||
            busy !== ebusy || overflow !== eovf) begin
            errors++;
            $display("FAIL %s: got v=%0b l=%0b d=%08h b=%0d busy=%0b ovf=%0b want v=%0b l=%0b d=%08h b=%0d busy=%0b ovf=%0b",
                     name, out_valid, out_last, out_data, out_bytes, busy, overflow,
                     ev, el, ed, eb, ebusy, eovf);
        end
    endtask

    task automatic cycle(input bit r, input bit dv, input bit fin,
                         input logic [4:0] fb, input logic [31:0] w);
        rst = r; data_valid = dv; final_in = fin; final_bits = fb; data_in = w;
        @(posedge clk);
        model_edge(r, dv, fin, fb, w);
        #1;
        compare("model", m_valid, m_last, m_data, m_bytes, m_drain, m_ovf);
    endtask

    typedef struct {
        bit          r, dv, fin;
        logic [4:0]  fb;
        logic [31:0] w;
        bit          ev, el;
        logic [31:0] ed;
        logic [2:0]  eb;
        bit          ebusy, eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        return w;
    endfunction

    initial begin
        //           r  dv fin fb  word          v  l  data          b  busy ovf
        vecs.push_back('{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'h12345678, 0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'h12345678, 4, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'h12345678, 4, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'hFF00FF11, 0, 0, 32'h12345678, 4, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'hAABBCCDD, 1, 0, 32'hFF0000FF, 4, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'h0011AABB, 4, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'h0011AABB, 4, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 0, 1, 5, 32'hA5000000, 0, 0, 32'h0,        0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 32'hA7000000, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'hA7000000, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 8, 32'hFF000000, 0, 0, 32'hA7000000, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 32'h11111111, 0, 0, 32'hA7000000, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 32'hFF000000, 2, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 32'h12345678, 0, 0, 32'hFF000000, 2, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'hFF000000, 2, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 32'h0,        0, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'hFFFFFFFF, 1, 0, 32'hFF00FF00, 4, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'hFFFFFFFF, 1, 0, 32'hFF00FF00, 4, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'hFFFFFFFF, 1, 0, 32'hFF00FF00, 4, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'hFF00FF00, 4, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'hFF00FF00, 4, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'hFF00FF00, 4, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'hFF00FF00, 4, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'hFF00FF00, 4, 0, 1});
        vecs.push_back('{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'hFF00FF11, 0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'hFF0000FF, 4, 0, 0});
        vecs.push_back('{0, 0, 1, 31, 32'hFFFFFFFF, 0, 0, 32'hFF0000FF, 4, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'h0011FF00, 4, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 32'h01020304, 0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 0, 32'h01020304, 4, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'h01020304, 4, 0, 0});

        foreach (vecs[k]) begin
            cycle(vecs[k].r, vecs[k].dv, vecs[k].fin, vecs[k].fb, vecs[k].w);
            compare($sformatf("vec%0d", k), vecs[k].ev, vecs[k].el, vecs[k].ed,
                    vecs[k].eb, vecs[k].ebusy, vecs[k].eovf);
        end

        // Randomized traffic: bursts, FF-heavy data, occasional finals and resets
        for (int n = 0; n < 4000; n++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 29) == 0,
                  5'($urandom_range(0, 31)),
                  rand_word());
        end
        for (int n = 0; n < 8; n++) cycle(0, 0, 0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
